window_scan_sequencer: RTL and testbench
========================================

# window_scan_sequencer

Control sequencer directly upstream of `column_index_counter` in the convolution front end. On a `start` pulse it walks the 12x12 input image as four 6x6 quadrants, each split into 2x2 non-overlapping 3x3 windows. It drives the counter's `en`, `clear`, `new_row`, `new_vector` and quadrant inputs, and itself supplies the matching pixel row index. It honours a pixel-ready stall from the image buffer and reports busy/done to the layer controller.

## Interface
- No parameters. Geometry is fixed: 12x12 image, 6x6 quadrants, 3x3 windows, stride 3.
- `clock`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high; forces IDLE
- `start`  in  1  one-cycle request to scan a full image; ignored unless IDLE
- `pixel_ready`  in  1  image buffer can deliver a pixel this cycle; low = stall
- `en`  out  1  advance strobe to `column_index_counter`; one pixel consumed
- `clear`  out  1  reloads the column counter with its quadrant base
- `new_row`  out  1  last column of a window row
- `new_vector`  out  1  last pixel of a 3x3 window
- `quadrant`  out  2  current quadrant: 00 TL, 01 TR, 10 BL, 11 BR; bit 0 feeds `quadrant_lsb`
- `row_index`  out  4  pixel row, 0..11
- `busy`  out  1  high from the cycle after an accepted `start` until DONE
- `done`  out  1  one-cycle pulse after the final pixel of quadrant 11

## Operation
- States:
  - IDLE: waiting for `start`.
  - LOAD: one cycle; `clear`=1, `en`=0.
  - SCAN: stepping through pixels.
  - DONE: one cycle; `done`=1.
- Transitions:
  - IDLE --start--> LOAD.
  - LOAD --> SCAN.
  - SCAN, last accepted pixel of a quadrant: to LOAD if `quadrant`!=11, else to DONE.
  - DONE --> IDLE.
- Position registers: `j` (column in window, 0..2), `r` (row in window, 0..2), `wc` (window column, 0..1), `wr` (window row, 0..1), `quadrant` (0..3).
- Loop nesting, innermost first: j, r, wc, wr, quadrant.
- `row_index` = 6*`quadrant`[1] + 3*`wr` + `r`. Combinational from registers, so it is valid in every state.
- SCAN outputs:
  - `en` = `pixel_ready`.
  - `new_row` = `en` && `j`==2.
  - `new_vector` = `en` && `j`==2 && `r`==2.
  - Every strobe is gated by `en`, so all strobes are 0 during a stall. This is required because the counter clears on `new_vector` regardless of `en`.
- Position update on each accepted pixel (`en`=1):
  - `j` increments.
  - On `j`==2: `j`<=0, `r` increments.
  - On `r`==2: `r`<=0, `wc` increments.
  - On `wc`==1: `wc`<=0, `wr` increments.
  - On `wr`==1: quadrant complete, `quadrant` increments.
- The `quadrant` increment takes effect before LOAD, so `clear` reloads the counter with the new quadrant's column base (0 or 6).
- Outside SCAN: `en`, `new_row` and `new_vector` are 0.
- `start` while not IDLE is ignored. A reset mid-scan abandons the image; no `done` is produced.

## Timing
- Reset values:
  - state IDLE; `j`, `r`, `wc`, `wr`, `quadrant` = 0.
  - `en`, `clear`, `new_row`, `new_vector`, `busy`, `done` = 0.
  - `row_index` = 0.
- Cycle counts:
  - `start` sampled at edge 0; LOAD is the cycle after edge 0.
  - With no stalls, each quadrant takes 1 LOAD + 36 SCAN cycles.
  - `done` pulses 148 cycles after the `start` edge; `busy` is high for those 148 cycles.
- A stall of N cycles delays every later event by exactly N; position registers hold during a stall.
- Edge cases:
  - `pixel_ready` low on the final pixel: the stay in SCAN is extended until that pixel is accepted.
  - `start` in the DONE cycle is ignored.
  - `start` in the IDLE cycle after DONE is accepted.
- Combined with `column_index_counter`, the counter reads columns 0,1,2,0,1,2,0,1,2,3,4,5,... for quadrant 00 and starts at 6 for quadrant 01.

## Structure
- Shared package `nn_geometry_pkg`:
  - state enum (IDLE/LOAD/SCAN/DONE);
  - constants IMG_DIM=12, QUAD_DIM=6, WIN_DIM=3, QUADRANTS=4.
- Single flat module with no sub-modules. The nested position counters are small enough to keep inline.

## Test plan
- Reset, then `start` with `pixel_ready`=1 throughout -> `done` at cycle 148, 144 `en` pulses, 48 `new_row`, 16 `new_vector`, 4 `clear` pulses, `quadrant` sequence 0,1,2,3.
- Same run with `column_index_counter` attached -> sampled column/row pairs cover each of the 144 pixels exactly once. Window 0 visits rows 0..2 x cols 0..2; quadrant 11 starts at row 6, col 6.
- `pixel_ready` low for 5 cycles at pixel 17 -> no strobes during the stall, positions frozen, `done` at cycle 153.
- `pixel_ready` low on the final pixel of quadrant 00 for 3 cycles -> no `new_vector` until accepted, then LOAD with `quadrant`=01 and `clear`=1.
- `reset` asserted mid-quadrant 10 -> all outputs 0 immediately, IDLE; a following `start` restarts at `quadrant`=00, `row_index`=0.
- `start` pulsed during SCAN and during DONE -> ignored, with no second LOAD and a single `done`.

Source files
------------

// File: rtl/nn_geometry_pkg.sv
// -----------------------------------------------------------------------------
// nn_geometry_pkg
// Shared geometry constants and the scan-sequencer state type for the
// convolution front end.
//   IMG_DIM   : square input image side (pixels)
//   QUAD_DIM  : quadrant side (pixels)
//   WIN_DIM   : window side and stride (pixels)
//   QUADRANTS : number of quadrants per image
// -----------------------------------------------------------------------------
package nn_geometry_pkg;

   localparam int IMG_DIM   = 12;
   localparam int QUAD_DIM  = 6;
   localparam int WIN_DIM   = 3;
   localparam int QUADRANTS = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      SCAN = 2'd2,
      DONE = 2'd3
   } scan_state_t;

endpackage : nn_geometry_pkg

// File: rtl/window_scan_sequencer.sv
// -----------------------------------------------------------------------------
// window_scan_sequencer
// Walks a 12x12 image as four 6x6 quadrants (TL, TR, BL, BR), each split into
// 2x2 non-overlapping 3x3 windows, and drives column_index_counter.
// Ports:
//   clock       in   rising-edge clock
//   reset       in   asynchronous active-high reset, forces IDLE
//   start       in   one-cycle scan request, honoured only in IDLE
//   pixel_ready in   image buffer can deliver a pixel (low = stall)
//   en          out  one pixel consumed this cycle
//   clear       out  reload column counter with the quadrant base
//   new_row     out  last column of a window row
//   new_vector  out  last pixel of a 3x3 window
//   quadrant    out  current quadrant (00 TL, 01 TR, 10 BL, 11 BR)
//   row_index   out  pixel row 0..11
//   busy        out  high during LOAD/SCAN
//   done        out  one-cycle pulse after the last pixel of the image
// -----------------------------------------------------------------------------
module window_scan_sequencer
   import nn_geometry_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic       pixel_ready,
   output logic       en,
   output logic       clear,
   output logic       new_row,
   output logic       new_vector,
   output logic [1:0] quadrant,
   output logic [3:0] row_index,
   output logic       busy,
   output logic       done
);

   localparam logic [1:0] LAST_IDX  = 2'(WIN_DIM - 1);
   localparam logic [1:0] LAST_QUAD = 2'(QUADRANTS - 1);

   scan_state_t state;
   logic [1:0]  j;     // column within window
   logic [1:0]  r;     // row within window
   logic        wc;    // window column within quadrant
   logic        wr;    // window row within quadrant

   logic last_col;
   logic last_row;

   assign last_col = (j == LAST_IDX);
   assign last_row = (r == LAST_IDX);

   // The strobes must follow pixel_ready in the same cycle, so they are decoded
   // from the registered state rather than registered themselves. Every strobe
   // is gated by en: the counter clears on new_vector even without en.
   always_comb begin
      en         = (state == SCAN) && pixel_ready;
      new_row    = en && last_col;
      new_vector = en && last_col && last_row;
      clear      = (state == LOAD);
      busy       = (state == LOAD) || (state == SCAN);
      done       = (state == DONE);
   end

   // Pixel row = quadrant row base + window row base + row within window.
   assign row_index = (quadrant[1] ? 4'(QUAD_DIM) : 4'd0)
                    + (wr ? 4'(WIN_DIM) : 4'd0)
                    + {2'b00, r};

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         j        <= 2'd0;
         r        <= 2'd0;
         wc       <= 1'b0;
         wr       <= 1'b0;
         quadrant <= 2'd0;
      end else begin
         case (state)
            IDLE: begin
               if (start) state <= LOAD;
            end
            LOAD: begin
               state <= SCAN;
            end
            SCAN: begin
               // Nested carry chain: j, r, wc, wr, quadrant. Positions hold
               // while stalled.
               if (en) begin
                  if (!last_col) begin
                     j <= j + 2'd1;
                  end else begin
                     j <= 2'd0;
                     if (!last_row) begin
                        r <= r + 2'd1;
                     end else begin
                        r  <= 2'd0;
                        wc <= ~wc;
                        if (wc) begin
                           wr <= ~wr;
                           if (wr) begin
                              // Quadrant advances before LOAD so clear picks
                              // up the new column base; wraps to 0 on DONE.
                              quadrant <= quadrant + 2'd1;
                              state    <= (quadrant == LAST_QUAD) ? DONE : LOAD;
                           end
                        end
                     end
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule : window_scan_sequencer

// File: tb/tb_window_scan_sequencer.sv
// -----------------------------------------------------------------------------
// tb_window_scan_sequencer
// Directed self-checking bench for window_scan_sequencer.
// -----------------------------------------------------------------------------
module tb_window_scan_sequencer;

   logic       clock;
   logic       reset;
   logic       start;
   logic       pixel_ready;
   logic       en;
   logic       clear;
   logic       new_row;
   logic       new_vector;
   logic [1:0] quadrant;
   logic [3:0] row_index;
   logic       busy;
   logic       done;

   int checks = 0;
   int errors = 0;
   int cov [12][12];

   window_scan_sequencer dut (
      .clock       (clock),
      .reset       (reset),
      .start       (start),
      .pixel_ready (pixel_ready),
      .en          (en),
      .clear       (clear),
      .new_row     (new_row),
      .new_vector  (new_vector),
      .quadrant    (quadrant),
      .row_index   (row_index),
      .busy        (busy),
      .done        (done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_en"},      32'(en),         0);
      chk({tag, "_clear"},   32'(clear),      0);
      chk({tag, "_new_row"}, 32'(new_row),    0);
      chk({tag, "_new_vec"}, 32'(new_vector), 0);
      chk({tag, "_busy"},    32'(busy),       0);
      chk({tag, "_done"},    32'(done),       0);
   endtask

   // Pulses start, then steps cycle by cycle against a position model.
   // Returns with time at 2 units after the edge that ends DONE (or at the
   // abort cycle). cyc counts edges after the start edge.
   task automatic run_scan(input int stall_at, input int stall_len,
                           input int start_scan_cyc, input bit start_done,
                           input int abort_cyc,
                           output int done_edge, output int n_en, output int n_row,
                           output int n_vec, output int n_clr);
      int cyc, acc, stall_rem, mq, mj, mr, mwc, mwr, mstate, exp_row;
      bit fin;
      done_edge = -1; n_en = 0; n_row = 0; n_vec = 0; n_clr = 0;
      acc = 0; mq = 0; mj = 0; mr = 0; mwc = 0; mwr = 0; mstate = 1;
      stall_rem = stall_len; fin = 0;
      for (int a = 0; a < 12; a++) for (int b = 0; b < 12; b++) cov[a][b] = 0;
      start = 1'b1;
      @(posedge clock); #2;
      start = 1'b0;
      cyc = 0;
      while (!fin && cyc < 400) begin
         if (abort_cyc >= 0 && cyc == abort_cyc) begin
            fin = 1;
         end else begin
            pixel_ready = 1'b1;
            if (mstate == 2 && acc == stall_at && stall_rem > 0) begin
               pixel_ready = 1'b0;
               stall_rem--;
            end
            start = (cyc == start_scan_cyc) || (mstate == 3 && start_done);
            #1;
            exp_row = 6 * (mq / 2) + 3 * mwr + mr;
            chk("row_index", 32'(row_index), 32'(exp_row));
            chk("quadrant",  32'(quadrant),  32'(mq));
            case (mstate)
               1: begin
                  chk("load_clear", 32'(clear), 1);
                  chk("load_en",    32'(en),    0);
                  chk("load_busy",  32'(busy),  1);
                  chk("load_done",  32'(done),  0);
                  n_clr++;
                  mstate = 2;
               end
               2: begin
                  chk("scan_clear",   32'(clear),      0);
                  chk("scan_busy",    32'(busy),       1);
                  chk("scan_done",    32'(done),       0);
                  chk("scan_en",      32'(en),         32'(pixel_ready));
                  chk("scan_new_row", 32'(new_row),    32'(pixel_ready && mj == 2));
                  chk("scan_new_vec", 32'(new_vector), 32'(pixel_ready && mj == 2 && mr == 2));
                  if (en) n_en++;
                  if (new_row) n_row++;
                  if (new_vector) n_vec++;
                  if (pixel_ready) begin
                     cov[exp_row][6 * (mq % 2) + 3 * mwc + mj]++;
                     acc++;
                     if (mj < 2) mj++;
                     else begin
                        mj = 0;
                        if (mr < 2) mr++;
                        else begin
                           mr = 0;
                           if (mwc < 1) mwc++;
                           else begin
                              mwc = 0;
                              if (mwr < 1) mwr++;
                              else begin
                                 mwr = 0;
                                 mstate = (mq == 3) ? 3 : 1;
                                 mq = (mq + 1) % 4;
                              end
                           end
                        end
                     end
                  end
               end
               default: begin
                  chk("done_pulse", 32'(done),  1);
                  chk("done_busy",  32'(busy),  0);
                  chk("done_en",    32'(en),    0);
                  chk("done_clear", 32'(clear), 0);
                  done_edge = cyc;
                  fin = 1;
               end
            endcase
            @(posedge clock); #2;
            start = 1'b0;
            cyc++;
         end
      end
      start = 1'b0;
      pixel_ready = 1'b1;
      if (abort_cyc < 0) chk("done_seen_in_budget", 32'(done_edge >= 0), 1);
   endtask

   int de, ne, nr, nv, nc, bad;

   initial begin
      reset = 1'b1; start = 1'b0; pixel_ready = 1'b1;
      #3;
      chk_idle("reset");
      chk("reset_quadrant",  32'(quadrant),  0);
      chk("reset_row_index", 32'(row_index), 0);
      @(posedge clock); #2;
      reset = 1'b0;
      @(posedge clock); #2;
      chk_idle("idle");

      // Full run; start pulsed mid-SCAN and in DONE must be ignored.
      run_scan(-1, 0, 50, 1'b1, -1, de, ne, nr, nv, nc);
      chk("run1_done_edge", 32'(de), 148);
      chk("run1_en_count",  32'(ne), 144);
      chk("run1_row_count", 32'(nr), 48);
      chk("run1_vec_count", 32'(nv), 16);
      chk("run1_clr_count", 32'(nc), 4);
      bad = 0;
      for (int a = 0; a < 12; a++) for (int b = 0; b < 12; b++) if (cov[a][b] != 1) bad++;
      chk("run1_pixel_cover", 32'(bad), 0);
      #1;
      chk_idle("after_done");
      chk("after_done_quadrant", 32'(quadrant), 0);

      // Start in the IDLE cycle right after DONE; 5-cycle stall at pixel 17.
      run_scan(17, 5, -1, 1'b0, -1, de, ne, nr, nv, nc);
      chk("run2_done_edge", 32'(de), 153);
      chk("run2_en_count",  32'(ne), 144);
      chk("run2_vec_count", 32'(nv), 16);

      // Stall on the final pixel of quadrant 00 for 3 cycles.
      run_scan(35, 3, -1, 1'b0, -1, de, ne, nr, nv, nc);
      chk("run3_done_edge", 32'(de), 151);
      chk("run3_clr_count", 32'(nc), 4);

      // Reset in the middle of quadrant 10.
      run_scan(-1, 0, -1, 1'b0, 84, de, ne, nr, nv, nc);
      chk("abort_busy_before", 32'(busy), 1);
      chk("abort_quadrant_before", 32'(quadrant), 2);
      reset = 1'b1;
      #1;
      chk_idle("abort_reset");
      chk("abort_quadrant",  32'(quadrant),  0);
      chk("abort_row_index", 32'(row_index), 0);
      @(posedge clock); #2;
      reset = 1'b0;
      @(posedge clock); #1;
      chk_idle("abort_idle");
      #1;
      run_scan(-1, 0, -1, 1'b0, -1, de, ne, nr, nv, nc);
      chk("run5_done_edge", 32'(de), 148);
      chk("run5_en_count",  32'(ne), 144);
      chk("run5_clr_count", 32'(nc), 4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_window_scan_sequencer
